// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller (master) and the
// IR/PC/memory datapath (slave).
interface multicycle_controller_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      inst;
   logic             zero;
   logic             mem_ready;
   logic             mem_read;
   logic             mem_write;
   logic             iord;
   logic             ir_write;
   logic             pc_write;
   logic [1:0]       pc_src;
   logic             alu_src;
   logic [1:0]       alu_op;
   logic             reg_write;
   logic             mem_to_reg;
   logic             link_sel;
   logic [2:0]       state;
   logic             illegal;
   logic             timeout_err;
   logic [CNT_W-1:0] instret;

   modport master (
      input  inst, zero, mem_ready,
      output mem_read, mem_write, iord, ir_write, pc_write, pc_src,
             alu_src, alu_op, reg_write, mem_to_reg, link_sel,
             state, illegal, timeout_err, instret
   );

   modport slave (
      output inst, zero, mem_ready,
      input  mem_read, mem_write, iord, ir_write, pc_write, pc_src,
             alu_src, alu_op, reg_write, mem_to_reg, link_sel,
             state, illegal, timeout_err, instret
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32-subset control FSM with memory-wait timeout and instret counter.
// Optional macro CTRL_JAL_EN adds jal (link write-back, pc_src=10).
module multicycle_controller #(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   multicycle_controller_if.master bus
);
   // state   | meaning
   // FETCH   | read instruction at PC, load IR and PC+4 on mem_ready
   // DECODE  | classify opcode, trap illegal
   // EXEC    | ALU operation; beq resolves and retires here
   // MEM     | data access for lw/sw, wait on mem_ready
   // WB      | register write-back, retire
   // HALT    | trap, absorbing until reset
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_NONE, C_BEQ, C_LW, C_SW, C_R, C_I, C_JAL
   } class_t;

   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
`ifdef CTRL_JAL_EN
   localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

   localparam int                WAIT_W   = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT_MAX);

   state_t             state_q, state_d;
   class_t             class_q, class_d;
   class_t             dec_class;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               illegal_q, illegal_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   instret_q;
   logic               retire;
   logic               timeout_hit;

   logic               mem_read_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
   logic               iord_c, pc_branch_c, alu_src_c, mem_to_reg_c;
   logic [1:0]         alu_op_c;
`ifdef CTRL_JAL_EN
   logic               pc_jump_c, link_sel_c;
`endif

   logic               unused_inst_bits;
   assign unused_inst_bits = ^bus.inst[31:7];

   always_comb begin
      dec_class = C_NONE;
      case (bus.inst[6:0])
         OP_BEQ:  dec_class = C_BEQ;
         OP_LW:   dec_class = C_LW;
         OP_SW:   dec_class = C_SW;
         OP_R:    dec_class = C_R;
         OP_I:    dec_class = C_I;
`ifdef CTRL_JAL_EN
         OP_JAL:  dec_class = C_JAL;
`endif
         default: dec_class = C_NONE;
      endcase
   end

   // Only reached while waiting (mem_ready low); a completion in the same cycle takes priority.
   assign timeout_hit = (MEM_WAIT_MAX != 0) && (wait_q == WAIT_MAX) && !bus.mem_ready;

   always_comb begin
      state_d      = state_q;
      class_d      = class_q;
      wait_d       = '0;
      illegal_d    = illegal_q;
      timeout_d    = timeout_q;
      retire       = 1'b0;
      mem_read_c   = 1'b0;
      mem_write_c  = 1'b0;
      ir_write_c   = 1'b0;
      pc_write_c   = 1'b0;
      reg_write_c  = 1'b0;
      iord_c       = 1'b0;
      pc_branch_c  = 1'b0;
      alu_src_c    = 1'b0;
      alu_op_c     = 2'b00;
      mem_to_reg_c = 1'b0;
`ifdef CTRL_JAL_EN
      pc_jump_c    = 1'b0;
      link_sel_c   = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            mem_read_c = 1'b1;
            if (bus.mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = S_DECODE;
            end else if (timeout_hit) begin
               timeout_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DECODE: begin
            class_d = dec_class;
            if (dec_class == C_NONE) begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (class_q)
               C_BEQ: begin
                  alu_op_c    = 2'b01;
                  pc_branch_c = 1'b1;
                  pc_write_c  = bus.zero;
                  retire      = 1'b1;
                  state_d     = S_FETCH;
               end
               C_LW, C_SW: begin
                  alu_src_c = 1'b1;
                  state_d   = S_MEM;
               end
               C_R: begin
                  alu_op_c = 2'b10;
                  state_d  = S_WB;
               end
               C_I: begin
                  alu_op_c  = 2'b10;
                  alu_src_c = 1'b1;
                  state_d   = S_WB;
               end
`ifdef CTRL_JAL_EN
               C_JAL: begin
                  pc_write_c = 1'b1;
                  pc_jump_c  = 1'b1;
                  state_d    = S_WB;
               end
`endif
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
            endcase
         end
         S_MEM: begin
            iord_c      = 1'b1;
            mem_read_c  = (class_q == C_LW);
            mem_write_c = (class_q == C_SW);
            if (bus.mem_ready) begin
               if (class_q == C_LW) begin
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (timeout_hit) begin
               timeout_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_WB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = (class_q == C_LW);
`ifdef CTRL_JAL_EN
            link_sel_c   = (class_q == C_JAL);
`endif
            retire       = 1'b1;
            state_d      = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         class_q   <= C_NONE;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
         if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
         end
      end
   end

   // Strobes are held off while reset is asserted, even though state_q already reads FETCH.
   assign bus.mem_read    = mem_read_c  & rst_n;
   assign bus.mem_write   = mem_write_c & rst_n;
   assign bus.ir_write    = ir_write_c  & rst_n;
   assign bus.pc_write    = pc_write_c  & rst_n;
   assign bus.reg_write   = reg_write_c & rst_n;
   assign bus.iord        = iord_c;
   assign bus.pc_src[0]   = pc_branch_c;
   assign bus.alu_src     = alu_src_c;
   assign bus.alu_op      = alu_op_c;
   assign bus.mem_to_reg  = mem_to_reg_c;
`ifdef CTRL_JAL_EN
   assign bus.pc_src[1]   = pc_jump_c;
   assign bus.link_sel    = link_sel_c;
`else
   assign bus.pc_src[1]   = 1'b0;
   assign bus.link_sel    = 1'b0;
`endif
   assign bus.state       = state_q;
   assign bus.illegal     = illegal_q;
   assign bus.timeout_err = timeout_q;
   assign bus.instret     = instret_q;
endmodule
